// File: rtl/seq_signed_divider.sv
// Iterative signed divider: restoring division on operand magnitudes, one quotient
// bit per enabled cycle, followed by a sign-correction cycle and a one-cycle done pulse.
module seq_signed_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_dvd_sh;
    logic [N-1:0]  r_dvs_mag;
    logic [N:0]    r_prem;
    logic [N-1:0]  r_quo;
    logic          r_neg_q;
    logic          r_neg_r;
    logic [N-1:0]  r_quotient;
    logic [N-1:0]  r_remainder;
    logic          r_dz;
    logic          r_ov;

    logic [N-1:0]  w_dvd_mag;
    logic [N-1:0]  w_dvs_mag;
    logic          w_div0;
    logic          w_ovf;
    logic          w_special;
    logic [N+1:0]  w_shift;
    logic [N+1:0]  w_trial;
    logic          w_qbit;

    // Magnitudes fit in N unsigned bits: the most negative value maps to 2^(N-1).
    assign w_dvd_mag = dividend[N-1] ? -dividend : dividend;
    assign w_dvs_mag = divisor[N-1]  ? -divisor  : divisor;
    assign w_div0    = (divisor == '0);
    assign w_ovf     = (dividend == MIN_VAL) && (divisor == '1);
    assign w_special = w_div0 || w_ovf;

    // Two guard bits so the trial difference sign is unambiguous for any magnitude.
    assign w_shift = {r_prem, r_dvd_sh[N-1]};
    assign w_trial = w_shift - {2'b00, r_dvs_mag};
    assign w_qbit  = ~w_trial[N+1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    w_next = w_special ? S_DONE : S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_dvd_sh    <= '0;
            r_dvs_mag   <= '0;
            r_prem      <= '0;
            r_quo       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
            r_ov        <= 1'b0;
        end else if (en) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_dvd_sh  <= w_dvd_mag;
                        r_dvs_mag <= w_dvs_mag;
                        r_prem    <= '0;
                        r_quo     <= '0;
                        r_neg_q   <= dividend[N-1] ^ divisor[N-1];
                        r_neg_r   <= dividend[N-1];
                        r_cnt     <= CW'(N);
                        r_dz      <= w_div0;
                        r_ov      <= w_ovf;
                        if (w_div0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                        end else if (w_ovf) begin
                            r_quotient  <= MIN_VAL;
                            r_remainder <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_prem   <= w_qbit ? w_trial[N:0] : w_shift[N:0];
                    r_dvd_sh <= {r_dvd_sh[N-2:0], 1'b0};
                    r_quo    <= {r_quo[N-2:0], w_qbit};
                    r_cnt    <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_quotient  <= r_neg_q ? -r_quo : r_quo;
                    r_remainder <= r_neg_r ? -r_prem[N-1:0] : r_prem[N-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (r_state == S_CALC) || (r_state == S_FIX);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dz;
    assign overflow    = r_ov;

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Iterative signed integer divider; the inverse operation of the team's registered radix-4 Booth multiplier.
- Accepts a dividend/divisor pair on a start pulse and computes one quotient bit per cycle (restoring, on magnitudes).
- Sign-corrects, then presents a registered quotient, remainder and exception flags with a one-cycle done pulse.
- Sits beside the multiplier in the arithmetic datapath and shares its clock, reset and enable scheme.

Parameters:
- N, 32, operand width in bits (two's complement); must be >= 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  clock enable; when 0, all state, counters and outputs hold
- start  input  1  request; sampled only when en=1 and state is IDLE or DONE
- dividend  input  N  signed dividend; captured on accepted start
- divisor  input  N  signed divisor; captured on accepted start
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse: results valid
- quotient  output  N  signed quotient, truncated toward zero
- remainder  output  N  signed remainder; sign follows dividend
- div_by_zero  output  1  divisor was 0
- overflow  output  1  dividend = -2^(N-1) and divisor = -1

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; busy, done, div_by_zero, overflow = 0; quotient, remainder = 0.
  - Reset asserted mid-operation aborts immediately; no done is ever produced for the aborted operation.
- States: IDLE, CALC, FIX, DONE. All transitions occur only on edges where en=1.
- IDLE / DONE, start=1 (accepted start):
  - Latch the operands, their signs and magnitudes (|x| held in N bits; -2^(N-1) becomes 2^(N-1) unsigned).
  - Clear div_by_zero and overflow. Load counter = N. Set busy=1.
  - If divisor==0 or the overflow pair is present, go to DONE; otherwise go to CALC.
- IDLE, start=0: stay in IDLE.
- DONE (lasts one cycle; done=1, busy=0): start=1 is accepted as above (back-to-back); otherwise go to IDLE.
- start is ignored in CALC and FIX.
- CALC, per cycle:
  - Shift the partial remainder (N+1 bits) left, bringing in the next dividend-magnitude MSB.
  - Trial-subtract the divisor magnitude; if the result is non-negative, keep it and set quotient bit = 1, else restore and set 0.
  - Decrement the counter; after N iterations go to FIX.
- FIX (one cycle):
  - Negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - Write quotient/remainder, then go to DONE.
- Special-case results (written on the edge that enters DONE):
  - div_by_zero: quotient = all ones, remainder = dividend, div_by_zero=1.
  - overflow: quotient = -2^(N-1), remainder = 0, overflow=1.
- Latency: start accepted on edge k.
  - Normal case: done=1 in the cycle after edge k+N+1, i.e. N+2 edges total.
  - Special case: done=1 after edge k+1.
- busy: high from edge k until the edge entering DONE.
- Holding: outputs and flags keep their values after done until the next accepted start. On that start the flags clear; quotient/remainder keep their old values until overwritten.
- en=0 in any state: freeze the state machine, counter and outputs. A done pulse is stretched for as long as en=0 holds in DONE.
- Arithmetic identity: dividend = quotient*divisor + remainder with |remainder| < |divisor|, for all non-exception inputs.

Test Plan:
- N=32, dividend=100, divisor=7 -> after 34 edges: done=1, quotient=14, remainder=2, flags 0; busy high for exactly 33 cycles.
- Signs: (-100)/7 -> q=-14, r=-2; 100/(-7) -> q=-14, r=2; (-100)/(-7) -> q=14, r=-2.
- 0x80000000 / 0xFFFFFFFF -> done 1 cycle after start edge; quotient=0x80000000, remainder=0, overflow=1. Then 0x80000000 / 2 -> q=0xC0000000, r=0, overflow=0.
- 1234/0 -> div_by_zero=1, quotient=0xFFFFFFFF, remainder=1234, done 1 cycle after start.
- Hold start high continuously with 50/5 -> a done pulse every 34 cycles with q=10, r=0. Drop en for 5 cycles mid-CALC -> done delayed by exactly 5 cycles, same result.
- Pull reset low at cycle 10 of a division -> all outputs 0 immediately; no done. A new start after release yields a correct result.
